// File: rtl/pl_intr_timer.sv
// Memory-mapped periodic/one-shot interrupt timer: queues up to 3 pending requests, intr = pend != 0.
// Events land PERIOD+1 cycles after the enable write; intr is registered; rdata is combinational from addr.
module pl_intr_timer #(
   parameter int unsigned        CNT_W      = 16,
   parameter logic [CNT_W-1:0]   DEF_PERIOD = CNT_W'(99)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic        inta,
   output logic        intr
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             en_q, en_d;
   logic             auto_q, auto_d;
   logic [1:0]       pend_q, pend_d;
   logic             ovr_q, ovr_d;
   logic             intr_q, intr_d;

   logic ev, dec, ctrl_wr, per_wr, stat_wr;
   logic unused_wdata;

   assign unused_wdata = ^wdata;
   assign ctrl_wr = we && (addr == 2'd0);
   assign per_wr  = we && (addr == 2'd1);
   assign stat_wr = we && (addr == 2'd3);
   assign ev      = (state_q == S_RUN) && (count_q == '0);
   assign dec     = inta && (pend_q != 2'd0);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      period_d = period_q;
      en_d     = en_q;
      auto_d   = auto_q;

      if (ev) begin
         if (auto_q) count_d = period_q;
         else        state_d = S_HOLD;
      end else if (state_q == S_RUN) begin
         count_d = count_q - CNT_W'(1);
      end

      // The expiry above has already been counted; the CTRL write then overrides the state.
      if (ctrl_wr) begin
         en_d   = wdata[0];
         auto_d = wdata[1];
         if (!wdata[0]) begin
            state_d = S_IDLE;
            count_d = count_q;
         end else if (state_q != S_RUN) begin
            state_d = S_RUN;
            count_d = period_q;
         end
      end

      if (per_wr) period_d = wdata[CNT_W-1:0];
   end

   always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (stat_wr && wdata[4]) ovr_d = 1'b0;
      if (ev && !dec) begin
         if (pend_q == 2'd3) ovr_d = 1'b1;
         else                pend_d = pend_q + 2'd1;
      end else if (dec && !ev) begin
         pend_d = pend_q - 2'd1;
      end
      intr_d = (pend_d != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         period_q <= DEF_PERIOD;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
         pend_q   <= 2'd0;
         ovr_q    <= 1'b0;
         intr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         period_q <= period_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
         pend_q   <= pend_d;
         ovr_q    <= ovr_d;
         intr_q   <= intr_d;
      end
   end

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0: rdata[1:0] = {auto_q, en_q};
         2'd1: rdata[CNT_W-1:0] = period_q;
         2'd2: rdata[CNT_W-1:0] = count_q;
         default: begin
            rdata[1:0] = pend_q;
            rdata[4]   = ovr_q;
         end
      endcase
   end

   assign intr = intr_q;

endmodule

// File: doc/pl_intr_timer.md
# pl_intr_timer

Programmable periodic interrupt source that drives the pipelined CPU's `intr` input and consumes its `inta` acknowledge. It sits on the CPU's data-memory bus as a small memory-mapped device. It counts down a programmable period and queues up to 3 pending requests. It holds `intr` high until every pending request has been acknowledged. It exercises the `int_entry` / `eret` path of the exception-capable pipeline.

## Interface
- `CNT_W`, 16, width of the period and count registers (range 4..32).
- `DEF_PERIOD`, 16'd99, PERIOD register value after reset.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `we` input 1: register write strobe, one cycle per write.
- `addr` input 2: register select (word index): 0 CTRL, 1 PERIOD, 2 COUNT, 3 STATUS.
- `wdata` input 32: write data.
- `rdata` output 32: read data, combinational from `addr`; unused bits read 0.
- `inta` input 1: interrupt acknowledge from the CPU, a one-cycle pulse.
- `intr` output 1: interrupt request, registered.

## Operation
- Registers:
  - CTRL[0] = `en`; CTRL[1] = `auto` (reload after expiry).
  - PERIOD[CNT_W-1:0]: the reload value.
  - COUNT: read-only; writes are ignored.
  - STATUS[1:0] = `pend` (0..3); STATUS[4] = `ovr` (sticky). Writing 1 to STATUS[4] clears `ovr`; other STATUS bits are read-only.
- States:
  - IDLE: disabled; COUNT holds its value.
  - RUN: COUNT decrements by 1 each cycle.
  - HOLD: one-shot has expired; COUNT = 0.
- Transitions:
  - IDLE/HOLD → RUN on a CTRL write with `en`=1. COUNT loads PERIOD on that write.
  - A CTRL write with `en`=1 while in RUN does not restart the count; it only updates `auto`.
  - Any state → IDLE on a CTRL write with `en`=0. `pend` and `ovr` are kept.
- Event: occurs in a cycle where state = RUN and COUNT = 0.
  - If `auto`=1: COUNT loads PERIOD and the state stays RUN.
  - If `auto`=0: the state goes to HOLD.
- Event spacing is PERIOD+1 cycles. PERIOD = 0 gives an event every cycle.
- A PERIOD write during RUN takes effect at the next reload, never mid-count.
- `pend` update at each edge:
  - event only: +1.
  - `inta` only with `pend` > 0: −1.
  - event and `inta` together: unchanged.
  - `inta` with `pend` = 0: ignored.
  - event with `pend` = 3 and no `inta`: `pend` stays 3 and `ovr` is set.
- `intr` is registered as (next `pend` != 0).
- A CTRL write and an event in the same cycle: the event is taken from the current state (it counts), then the write's state change applies.
- A STATUS write that clears `ovr` in the same cycle as a new overflow leaves `ovr` = 1 (set wins).

## Timing
- Reset values:
  - state IDLE; COUNT 0; PERIOD = DEF_PERIOD; CTRL 0.
  - `pend` 0; `ovr` 0; `intr` 0.
  - `rdata` reflects these reset values.
- Latency:
  - From the CTRL enable write edge to the first event: PERIOD+1 cycles.
  - `intr` rises at the edge that registers the event.
  - `intr` falls at the edge that samples the `inta` which brings `pend` to 0.
- `rst` asserted mid-count or with `pend` > 0 discards everything. `intr` is low the cycle after the reset edge.
- COUNT wrap: COUNT never decrements below 0. At 0 it is reloaded (`auto`=1) or frozen (HOLD).
- `rdata` is valid in the same cycle as `addr`. A read of a register being written that cycle returns the old value.

## Test plan
- Reset; write PERIOD = 4, CTRL = 3 at cycle 0 → events at cycles 5, 10, 15. `intr` is high from the cycle-5 edge onward while nothing is acknowledged. STATUS `pend` reads 1, 2, 3.
- Continue without `inta` to the cycle-20 event → `pend` = 3, `ovr` = 1. Then 3 `inta` pulses → `pend` steps 2, 1, 0 and `intr` drops after the third. Write 0x10 to STATUS → `ovr` = 0.
- One-shot: PERIOD = 2, CTRL = 1 → a single event at cycle 3. State HOLD, COUNT reads 0, no further events over 20 cycles. Re-writing CTRL = 1 restarts the count.
- `inta` in the same cycle as an event with `pend` = 1 → `pend` stays 1 and `intr` stays high.
- PERIOD = 0 with `auto` → one event per cycle. `inta` every cycle → `pend` stays at 1.
- Disable mid-count (CTRL = 0 at COUNT = 2) → COUNT frozen at 2, `pend` kept. `rst` pulse mid-RUN → all outputs at their reset values on the next cycle.
